mux_2to1_4bit: RTL and testbench
================================

Name: mux_2to1_4bit

Overview:
- Parameterised 2:1 word multiplexer, default 4 bits wide, built as WIDTH parallel 1-bit 2:1 mux cells that share one select line.
- Provides a combinational output y for immediate use.
- Provides a registered copy y_q plus a valid flag and a select-toggle counter for pipelined consumers and debug.
- Sits in datapath steering logic wherever one of two operand words must be chosen.

Parameters:
- WIDTH, 4, data width of I0, I1, y, y_q; must be ≥1.
- CNT_W, 8, width of the select-toggle counter.

Ports:
- clk  input  1  rising-edge clock for all registered outputs
- rst_n  input  1  synchronous active-low reset
- S  input  1  select: 0 chooses I0, 1 chooses I1
- I0  input  WIDTH  data input 0
- I1  input  WIDTH  data input 1
- y  output  WIDTH  combinational mux output
- y_q  output  WIDTH  registered mux output
- y_valid  output  1  high when y_q holds a value sampled since reset
- sel_toggles  output  CNT_W  count of S value changes observed at clock edges since reset, saturating

Behaviour:
- Combinational path:
  - y[i] = S ? I1[i] : I0[i] for every bit i; implemented as WIDTH instances of a 1-bit 2:1 mux cell.
  - No clock dependency; y is valid in the same delta as input changes, including during reset.
  - S = X/Z: for any bit where I0[i] == I1[i], y[i] equals that value; otherwise y[i] is X in simulation.
- Reset (synchronous, rst_n = 0 at a rising clk edge):
  - y_q <= 0, y_valid <= 0, sel_toggles <= 0.
  - The internal previous-select register s_prev <= 0.
  - The combinational output y is unaffected by reset.
- Normal operation (rst_n = 1, every rising clk edge):
  - y_q <= y, i.e. one-cycle latency from inputs to y_q.
  - y_valid <= 1; it stays 1 until the next reset.
  - s_prev <= S.
  - If y_valid == 1 and S != s_prev, sel_toggles increments by 1.
  - The counter saturates at all-ones; it never wraps.
  - The first edge after reset does not count a toggle, because y_valid is still 0.
- Reset mid-operation: the registered state clears on the reset edge. The first post-reset edge with rst_n = 1 loads y_q and sets y_valid.
- Simultaneous input change and clock edge: values sampled are those stable at the edge. Standard setup/hold rules apply; there is no internal synchronisation.
- No handshake; the block is always ready.

Test Plan:
- Combinational select: I0=4'hA, I1=4'h5, S=0 → y=4'hA. Then S=1 → y=4'h5 with no clock edge needed.
- Equal inputs, X select: I0=I1=4'h9, S=X → y=4'h9. Then I0=4'h3, I1=4'hC, S=0 → y=4'h3, and S=1 → y=4'hC.
- Random sweep: 5+ vectors of {I0,I1,S} = random 9-bit value, checked 10 time units after each apply. For example 9'h124 → I0=4'h9, I1=4'h2, S=0, y=4'h9; 9'h181 → I0=4'hC, I1=4'h0, S=1, y=4'h0.
- Register and reset:
  - rst_n=0 for 2 edges → y_q=0, y_valid=0, sel_toggles=0.
  - Release with I0=4'h7, S=0 → after 1 edge y_q=4'h7, y_valid=1.
  - Assert rst_n=0 mid-stream → y_q=0 and y_valid=0 after that edge, while y still tracks the inputs.
- Toggle counter: after reset, alternate S every clock for 10 edges → sel_toggles=9 (first edge not counted). With CNT_W=2 and 10 toggles → sel_toggles saturates at 3.
- Width parameter: WIDTH=1, I0=0, I1=1, S=1 → y=1, and y_q=1 after 1 edge.

Source files
------------

// File: rtl/mux_2to1_4bit_if.sv
// rtl/mux_2to1_4bit_if.sv - select/data bundle for the 2:1 word multiplexer
interface mux_2to1_4bit_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             S;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_valid;
  logic [CNT_W-1:0] sel_toggles;

  modport master (
    output S, I0, I1,
    input  y, y_q, y_valid, sel_toggles
  );

  modport slave (
    input  S, I0, I1,
    output y, y_q, y_valid, sel_toggles
  );
endinterface

// File: rtl/mux_2to1_4bit.sv
// rtl/mux_2to1_4bit.sv - 2:1 word mux with registered copy and select-toggle counter
module mux_cell_2to1 (
  input  logic i_s,
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  // ?: keeps agreeing data bits resolved when the select is unknown
  assign o_y = i_s ? i_b : i_a;
endmodule

module mux_2to1_4bit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_2to1_4bit_if.slave bus
);
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic             r_y_valid;
  logic             r_s_prev;
  logic [CNT_W-1:0] r_sel_toggles;
  logic             w_toggle;
  logic             w_cnt_full;

  // One bit-cell per data bit, all sharing the select line
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    mux_cell_2to1 u_cell (
      .i_s (bus.S),
      .i_a (bus.I0[g]),
      .i_b (bus.I1[g]),
      .o_y (w_y[g])
    );
  end

  // A toggle only counts once a prior sample exists to compare against
  assign w_toggle   = r_y_valid && (bus.S != r_s_prev);
  assign w_cnt_full = &r_sel_toggles;

  // Registered copy, valid flag, previous select and saturating toggle count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q         <= '0;
      r_y_valid     <= 1'b0;
      r_s_prev      <= 1'b0;
      r_sel_toggles <= '0;
    end else begin
      r_y_q     <= w_y;
      r_y_valid <= 1'b1;
      r_s_prev  <= bus.S;
      if (w_toggle && !w_cnt_full) begin
        r_sel_toggles <= r_sel_toggles + CNT_W'(1);
      end
    end
  end

  assign bus.y           = w_y;
  assign bus.y_q         = r_y_q;
  assign bus.y_valid     = r_y_valid;
  assign bus.sel_toggles = r_sel_toggles;
endmodule

// File: tb/tb_mux_2to1_4bit.sv
// tb/tb_mux_2to1_4bit.sv - randomized self-checking bench for mux_2to1_4bit
module tb_mux_2to1_4bit;
  logic       clk;
  logic       rst_n;
  logic       s;
  logic [3:0] i0;
  logic [3:0] i1;

  int tests;
  int fails;

  // reference state: plain counters and last-sample values
  logic [3:0] m_yq;
  logic       m_valid;
  logic       m_sprev;
  int         m_cnt;

  mux_2to1_4bit_if #(.WIDTH(4), .CNT_W(8)) if_a ();
  mux_2to1_4bit_if #(.WIDTH(4), .CNT_W(2)) if_b ();
  mux_2to1_4bit_if #(.WIDTH(1), .CNT_W(8)) if_c ();

  assign if_a.S  = s;
  assign if_a.I0 = i0;
  assign if_a.I1 = i1;
  assign if_b.S  = s;
  assign if_b.I0 = i0;
  assign if_b.I1 = i1;
  assign if_c.S  = s;
  assign if_c.I0 = i0[0];
  assign if_c.I1 = i1[0];

  mux_2to1_4bit #(.WIDTH(4), .CNT_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  mux_2to1_4bit #(.WIDTH(4), .CNT_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  mux_2to1_4bit #(.WIDTH(1), .CNT_W(8)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: at each edge take the selected word, count select changes
  always @(posedge clk) begin
    if (!rst_n) begin
      m_yq    = 4'h0;
      m_valid = 1'b0;
      m_sprev = 1'b0;
      m_cnt   = 0;
    end else begin
      if (m_valid && (s !== m_sprev)) m_cnt = m_cnt + 1;
      m_yq    = s ? i1 : i0;
      m_valid = 1'b1;
      m_sprev = s;
    end
  end

  function automatic int sat(input int cnt, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (cnt > lim) ? lim : cnt;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] ey;
    ey = s ? i1 : i0;
    check({tag, ".y_a"},   32'(if_a.y), 32'(ey));
    check({tag, ".y_c"},   32'(if_c.y), 32'(ey[0]));
    check({tag, ".yq_a"},  32'(if_a.y_q), 32'(m_yq));
    check({tag, ".yq_c"},  32'(if_c.y_q), 32'(m_yq[0]));
    check({tag, ".vld_a"}, 32'(if_a.y_valid), 32'(m_valid));
    check({tag, ".vld_b"}, 32'(if_b.y_valid), 32'(m_valid));
    check({tag, ".tgl_a"}, 32'(if_a.sel_toggles), 32'(sat(m_cnt, 8)));
    check({tag, ".tgl_b"}, 32'(if_b.sel_toggles), 32'(sat(m_cnt, 2)));
  endtask

  initial begin
    logic [8:0] v;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    s  = 1'b0;
    i0 = 4'h0;
    i1 = 4'h0;

    // combinational checks while reset is held: y must ignore reset
    i0 = 4'hA; i1 = 4'h5; s = 1'b0; #3;
    check("comb_s0", 32'(if_a.y), 32'h0000000A);
    s = 1'b1; #3;
    check("comb_s1", 32'(if_a.y), 32'h00000005);
    i0 = 4'h9; i1 = 4'h9; s = 1'bx; #3;
    check("comb_sx", 32'(if_a.y), 32'h00000009);
    i0 = 4'h3; i1 = 4'hC; s = 1'b0; #3;
    check("comb_3", 32'(if_a.y), 32'h00000003);
    s = 1'b1; #3;
    check("comb_C", 32'(if_a.y), 32'h0000000C);

    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 9'h124;
      else if (k == 1) v = 9'h181;
      else             v = 9'($urandom);
      i0 = v[8:5];
      i1 = v[4:1];
      s  = v[0];
      #10;
      check("sweep_y", 32'(if_a.y), 32'(v[0] ? v[4:1] : v[8:5]));
      check("sweep_y1", 32'(if_c.y), 32'(v[0] ? v[1] : v[5]));
    end

    // reset state after at least two reset edges
    s = 1'b0;
    tick();
    tick();
    check("rst_yq", 32'(if_a.y_q), 32'h0);
    check("rst_vld", 32'(if_a.y_valid), 32'h0);
    check("rst_tgl", 32'(if_a.sel_toggles), 32'h0);
    check_all("rst");

    // release with I0=7, S=0
    i0 = 4'h7; i1 = 4'h1; s = 1'b0; rst_n = 1'b1;
    tick();
    check("rel_yq", 32'(if_a.y_q), 32'h7);
    check("rel_vld", 32'(if_a.y_valid), 32'h1);
    check_all("rel");

    // randomized register operation
    for (int k = 0; k < 40; k++) begin
      i0 = 4'($urandom);
      i1 = 4'($urandom);
      s  = 1'($urandom);
      tick();
      check_all("rnd");
    end

    // mid-stream reset: registers clear, y keeps tracking
    rst_n = 1'b0;
    i0 = 4'($urandom); i1 = 4'($urandom); s = 1'b1;
    tick();
    check("mid_yq", 32'(if_a.y_q), 32'h0);
    check("mid_vld", 32'(if_a.y_valid), 32'h0);
    check("mid_y", 32'(if_a.y), 32'(i1));
    check_all("mid");

    // toggle counter: first edge after reset is not counted
    s = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s = ~s;
      tick();
    end
    check("tgl_9", 32'(if_a.sel_toggles), 32'd9);
    check("tgl_sat2", 32'(if_b.sel_toggles), 32'd3);
    check_all("tgl");

    // drive the 8-bit counter into saturation
    for (int k = 0; k < 260; k++) begin
      s = ~s;
      tick();
    end
    check("tgl_sat8", 32'(if_a.sel_toggles), 32'd255);
    check_all("sat");

    // 1-bit instance: I0=0, I1=1, S=1
    i0 = 4'h0; i1 = 4'h1; s = 1'b1; #1;
    check("w1_y", 32'(if_c.y), 32'h1);
    tick();
    check("w1_yq", 32'(if_c.y_q), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
